operand_sequencer: RTL and testbench
====================================

Name: operand_sequencer

Overview:
- Upstream feeder for the 8-bit arithmetic circuit (FSM + datapath computing on four operands).
- Accepts operand bytes over a valid/ready stream and assembles a, b, c, d and mode.
- Issues a one-cycle start, holds the operands stable until done, then captures the 8-bit result i.
- Presents the captured result on a valid/ready output stream.
- Detects a missing done with a timeout.

Parameters:
- TIMEOUT_CYCLES, 255: maximum WAIT-state cycles before timeout_err; legal range 1..255.
- TIMER_W, 8: width of the WAIT cycle counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream byte valid.
- in_data  input  8  operand byte; the k-th accepted byte of a batch loads a, b, c, d for k = 0..3.
- in_mode  input  1  mode bit; sampled only with byte 0.
- in_ready  output  1  sequencer can accept a byte.
- a, b, c, d  output  8 each  operands to the circuit.
- mode  output  1  mode to the circuit.
- start  output  1  start pulse to the circuit.
- i  input  8  result from the circuit.
- done  input  1  completion from the circuit.
- res_valid  output  1  captured result available.
- res_data  output  8  captured result.
- res_ready  input  1  downstream accepts the result.
- busy  output  1  high in START, WAIT and OUT.
- timeout_err  output  1  sticky timeout flag.
- err_clear  input  1  clears timeout_err and returns to LOAD.

Behaviour:
- Reset values: a = b = c = d = 0, mode = 0, res_data = 0; start, res_valid, busy and timeout_err all 0; in_ready = 0 while reset is high.
- After reset: state = LOAD, byte index idx = 0, timer = 0.
- Reset asserted mid-operation aborts immediately to these values. No partial batch survives.
- States: LOAD, START, WAIT, OUT, ERR.
- LOAD:
  - in_ready = 1 (and not reset).
  - Byte accepted when in_valid & in_ready; stored into the operand selected by idx; idx increments.
  - Byte 0 also latches mode <= in_mode.
  - On acceptance with idx = 3: idx <= 0, next state = START.
  - in_valid low: hold; no partial-batch timeout.
- START:
  - start = 1 for exactly this one cycle; in_ready = 0; timer <= 0; next state = WAIT.
  - done is ignored in this state.
- WAIT:
  - start = 0; a, b, c, d and mode are held unchanged.
  - done = 1: res_data <= i (sampled that same cycle), next state = OUT.
  - done = 0 and timer = TIMEOUT_CYCLES-1: timeout_err <= 1, next state = ERR.
  - Otherwise timer increments.
  - done on the final timeout cycle wins; no error is raised.
- OUT:
  - res_valid = 1; res_data is stable while res_valid is high and res_ready is low.
  - On res_ready: next state = LOAD, res_valid drops next cycle.
  - in_ready = 0 throughout, so a new batch cannot start before the result is taken.
  - res_ready already high on entry: exactly one cycle in OUT.
- ERR:
  - in_ready = 0; res_valid = 0; timeout_err held.
  - done is ignored.
  - err_clear: timeout_err <= 0, idx <= 0, next state = LOAD.
- Outside ERR, err_clear has no effect.
- done outside WAIT is ignored in all states.
- Operands persist after a batch until overwritten; new bytes overwrite them one at a time.
- Minimum latency, byte 3 accepted to res_valid high: 3 cycles (START, WAIT with done=1, OUT).

Test Plan:
- Basic batch:
  - Stimulus: bytes 0x12, 0x34, 0x56, 0x78 back to back with in_mode = 1 on byte 0; stub asserts done 2 cycles after start with i = 0xAB.
  - Required: a..d = 0x12/0x34/0x56/0x78, mode = 1; start high exactly 1 cycle; res_valid with res_data = 0xAB; in_ready = 0 until res_ready.
- Gapped input and backpressure:
  - Stimulus: in_valid toggles every other cycle; res_ready held low 5 cycles after res_valid.
  - Required: only 4 bytes accepted; res_data stable across all 5 cycles; LOAD re-entered the cycle after res_ready.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 4; done never asserts.
  - Required: timeout_err = 1 after 4 WAIT cycles; in_ready = 0 until err_clear; err_clear returns in_ready = 1 with idx = 0.
- Boundary done:
  - Stimulus: TIMEOUT_CYCLES = 4; done on the 4th WAIT cycle with i = 0x5A.
  - Required: no error; res_data = 0x5A.
- Spurious done:
  - Stimulus: done pulsed during LOAD and during START.
  - Required: no state change; no capture.
- Reset mid-operation:
  - Stimulus: reset during WAIT, then a fresh batch 0x01..0x04.
  - Required: all outputs at reset values; new batch is loaded from byte 0 and completes normally.

Source files
------------

// File: rtl/operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : operand_sequencer
//  Purpose  : Feeder for the 8-bit four-operand arithmetic circuit. It collects
//             four operand bytes from a valid/ready stream and issues a single
//             start pulse. The operands are held until done arrives. It then
//             captures the result and offers it on a valid/ready output
//             stream. A missing done is flagged by a sticky timeout error.
//  Ports    : clk, reset              - clock, synchronous active-high reset
//             in_valid/in_data/in_mode/in_ready - operand byte input stream
//             a, b, c, d, mode, start - operand/control outputs to the circuit
//             i, done                 - result and completion from the circuit
//             res_valid/res_data/res_ready - result output stream
//             busy                    - high in START, WAIT and OUT
//             timeout_err, err_clear  - sticky timeout flag and its clear
//  Revision : 1.0 - initial release
// ============================================================================
module operand_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,  // legal range 1..255
  parameter int TIMER_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_mode,
  output logic       in_ready,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [7:0] c,
  output logic [7:0] d,
  output logic       mode,
  output logic       start,
  input  logic [7:0] i,
  input  logic       done,
  output logic       res_valid,
  output logic [7:0] res_data,
  input  logic       res_ready,
  output logic       busy,
  output logic       timeout_err,
  input  logic       err_clear
);

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    OUT   = 3'd3,
    ERR   = 3'd4
  } state_t;

  // Last timer value before giving up. The timer counts WAIT cycles starting
  // from 0, so this is the TIMEOUT_CYCLES-th WAIT cycle.
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_t             state;
  logic [1:0]         idx;
  logic [TIMER_W-1:0] timer;

  // in_ready is decoded directly from the state. This lets it drop in the same
  // cycle that reset is raised, with no wait for the next edge.
  assign in_ready = (state == LOAD) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOAD;
      idx         <= 2'd0;
      timer       <= '0;
      a           <= 8'h00;
      b           <= 8'h00;
      c           <= 8'h00;
      d           <= 8'h00;
      mode        <= 1'b0;
      start       <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= 8'h00;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          // in_ready is already high here, because reset is low in this branch.
          if (in_valid) begin
            case (idx)
              2'd0: begin
                a    <= in_data;
                mode <= in_mode;
              end
              2'd1: b <= in_data;
              2'd2: c <= in_data;
              default: d <= in_data;
            endcase
            if (idx == 2'd3) begin
              idx   <= 2'd0;
              state <= START;
              start <= 1'b1;
              busy  <= 1'b1;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end

        START: begin
          // This state ignores done. The pulse lasts exactly one cycle.
          start <= 1'b0;
          timer <= '0;
          state <= WAIT;
        end

        WAIT: begin
          // done is checked before the timeout. A done on the last cycle
          // therefore still completes normally.
          if (done) begin
            res_data  <= i;
            res_valid <= 1'b1;
            state     <= OUT;
          end else if (timer == TIMER_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= ERR;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= LOAD;
          end
        end

        ERR: begin
          if (err_clear) begin
            timeout_err <= 1'b0;
            idx         <= 2'd0;
            state       <= LOAD;
          end
        end

        default: begin
          state     <= LOAD;
          idx       <= 2'd0;
          start     <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_sequencer
//  Purpose  : Self-checking bench for operand_sequencer. A procedural stub
//             stands in for the arithmetic circuit. Expected results are queued
//             when the stub drives done, then popped when the result is handed
//             over on the output stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_operand_sequencer;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_mode;
  logic       in_ready;
  logic [7:0] a, b, c, d;
  logic       mode;
  logic       start;
  logic [7:0] i;
  logic       done;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_ready;
  logic       busy;
  logic       timeout_err;
  logic       err_clear;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_res = 8'h00;

  always #5 clk = ~clk;

  operand_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .TIMER_W       (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .mode       (mode),
    .start      (start),
    .i          (i),
    .done       (done),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ready  (res_ready),
    .busy       (busy),
    .timeout_err(timeout_err),
    .err_clear  (err_clear)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_vals();
    check("rst_a", a, 0);
    check("rst_b", b, 0);
    check("rst_c", c, 0);
    check("rst_d", d, 0);
    check("rst_mode", mode, 0);
    check("rst_res_data", res_data, 0);
    check("rst_start", start, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
  endtask

  // Runs one batch. done_at is the WAIT cycle (1-based) on which done is
  // asserted, and 0 means done never comes. hold is the number of OUT cycles
  // with res_ready held low. abort raises reset in the first WAIT cycle.
  task automatic run_batch(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input logic md, input bit gap, input int done_at,
                           input logic [7:0] rv, input int hold, input bit abort);
    logic [7:0] bytes[4];
    int  acc;
    int  cyc;
    bit  tog;
    logic [7:0] exp_r;
    bytes = '{b0, b1, b2, b3};
    acc = 0;
    cyc = 0;
    tog = 1'b0;
    while (acc < 4 && cyc < 40) begin
      tog      = !tog;
      in_valid = gap ? tog : 1'b1;
      in_data  = bytes[acc];
      in_mode  = (acc == 0) ? md : ~md;  // mode must come from byte 0 only
      if (in_valid && in_ready) acc++;
      step();
      cyc++;
    end
    // Keep offering junk. None of it may be accepted until the result is taken.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_mode  = ~md;
    check("bytes_accepted", acc, 4);

    // START cycle
    check("start_high", start, 1);
    check("in_ready_start", in_ready, 0);
    check("busy_start", busy, 1);
    check("op_a", a, b0);
    check("op_b", b, b1);
    check("op_c", c, b2);
    check("op_d", d, b3);
    check("op_mode", mode, md);
    done = 1'b1;            // spurious done in START
    i    = 8'hEE;
    step();
    done = 1'b0;
    check("start_one_cycle", start, 0);

    if (abort) begin
      in_valid = 1'b0;
      reset    = 1'b1;
      #1;
      check("in_ready_in_reset", in_ready, 0);
      step();
      check_reset_vals();
      check("in_ready_in_reset2", in_ready, 0);
      reset = 1'b0;
      step();
      check("in_ready_after_abort", in_ready, 1);
      return;
    end

    for (int w = 1; w <= TO; w++) begin
      check("in_ready_wait", in_ready, 0);
      check("no_err_wait", timeout_err, 0);
      check("no_valid_wait", res_valid, 0);
      if (w == done_at) begin
        done = 1'b1;
        i    = rv;
        exp_q.push_back(rv);
      end
      step();
      done = 1'b0;
      i    = 8'hEE;
      if (w == done_at) break;
    end
    in_valid = 1'b0;

    if (done_at == 0) begin
      check("timeout_err_set", timeout_err, 1);
      check("busy_err", busy, 0);
      check("res_valid_err", res_valid, 0);
      check("in_ready_err", in_ready, 0);
      done = 1'b1;          // ignored in ERR
      i    = 8'h77;
      step();
      done = 1'b0;
      check("err_sticky", timeout_err, 1);
      check("err_no_capture", res_data, last_res);
      check("err_no_valid", res_valid, 0);
      repeat (2) begin
        check("in_ready_err_hold", in_ready, 0);
        step();
      end
      err_clear = 1'b1;
      step();
      err_clear = 1'b0;
      check("err_cleared", timeout_err, 0);
      check("in_ready_after_clear", in_ready, 1);
      check("busy_after_clear", busy, 0);
      return;
    end

    // OUT
    check("res_valid_out", res_valid, 1);
    check("busy_out", busy, 1);
    check("op_a_held", a, b0);
    check("op_d_held", d, b3);
    check("mode_held", mode, md);
    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      check("res_valid_hold", res_valid, 1);
      check("res_data_hold", res_data, exp_q[0]);
      check("in_ready_hold", in_ready, 0);
      step();
    end
    res_ready = 1'b1;
    check("res_valid_take", res_valid, 1);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      exp_r = exp_q.pop_front();
      check("res_data", res_data, exp_r);
      last_res = exp_r;
    end
    step();
    res_ready = 1'b0;
    check("res_valid_drop", res_valid, 0);
    check("in_ready_reload", in_ready, 1);
    check("busy_idle", busy, 0);
    check("no_err_done", timeout_err, 0);
    check("op_a_persist", a, b0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_mode   = 1'b0;
    i         = 8'h00;
    done      = 1'b0;
    res_ready = 1'b0;
    err_clear = 1'b0;
    repeat (3) step();
    check_reset_vals();
    check("in_ready_reset", in_ready, 0);
    reset = 1'b0;
    step();
    check("in_ready_idle", in_ready, 1);

    // Spurious done and err_clear in LOAD
    done      = 1'b1;
    i         = 8'hEE;
    err_clear = 1'b1;
    step();
    done      = 1'b0;
    err_clear = 1'b0;
    check("spur_load_ready", in_ready, 1);
    check("spur_load_valid", res_valid, 0);
    check("spur_load_data", res_data, 0);
    check("spur_load_busy", busy, 0);

    run_batch(8'h12, 8'h34, 8'h56, 8'h78, 1'b1, 1'b0, 2, 8'hAB, 0, 1'b0);  // basic
    run_batch(8'hC3, 8'h3C, 8'h99, 8'h66, 1'b0, 1'b1, 1, 8'h17, 5, 1'b0);  // gapped + backpressure
    run_batch(8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 1'b0, 0, 8'h00, 0, 1'b0);  // timeout
    run_batch(8'hA5, 8'h5A, 8'hF0, 8'h0F, 1'b0, 1'b0, TO, 8'h5A, 2, 1'b0); // done on last cycle
    run_batch(8'hDE, 8'hAD, 8'hBE, 8'hEF, 1'b1, 1'b0, 0, 8'h00, 0, 1'b1);  // reset in WAIT
    run_batch(8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 1'b0, 3, 8'hC9, 1, 1'b0);  // fresh batch

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
